// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC constants and types used by the output-port slice
package noc_pkg;
    localparam int NOC_FLIT_W   = 64;
    localparam int NOC_HOP_MSB  = 55;
    localparam int NOC_HOP_LSB  = 48;
    localparam int NOC_VC_DEPTH = 2;
    typedef enum logic {VC0 = 1'b0, VC1 = 1'b1} vc_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, search starts at ptr and wraps modulo N
// Ports: clk, reset (sync, active-high); req[N] requests;
//        advance allows a grant this cycle; gnt[N] one-hot grant or zero;
//        ptr current search start, moves to winner+1 only on a grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N-1:0]                 req,
    input  logic                         advance,
    output logic [N-1:0]                 gnt,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0] ptr
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[PW'((int'(ptr) + k) % N)]) begin
                found = 1'b1;
                win   = PW'((int'(ptr) + k) % N);
            end
        end
    end

    assign gnt = (found && advance) ? (N'(1) << win) : '0;

    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (|gnt)
            ptr <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
    end
endmodule

// File: rtl/vc_output_port.sv
// vc_output_port: two-VC output port; fills VC[~polarity] from NIN inputs, drains VC[polarity] to the link
// Ports: clk, reset (sync, active-high); polarity selects the draining VC;
//        fwd_v/fwd_d/fwd_en per-input valid, packed flits, one-hot accept;
//        so/ro/dout link valid, ready and head flit; vc_cnt {VC1 count, VC0 count}.
module vc_output_port
    import noc_pkg::*;
#(
    parameter int DW      = NOC_FLIT_W,
    parameter int NIN     = 4,
    parameter int DEPTH   = NOC_VC_DEPTH,
    parameter int HOP_MSB = NOC_HOP_MSB,
    parameter int HOP_LSB = NOC_HOP_LSB,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic [NIN-1:0]    fwd_v,
    input  logic [NIN*DW-1:0] fwd_d,
    output logic [NIN-1:0]    fwd_en,
    output logic              so,
    input  logic              ro,
    output logic [DW-1:0]     dout,
    output logic [2*CW-1:0]   vc_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = $clog2(NIN);

    vc_e           fill_vc;
    vc_e           drain_vc;
    logic [DW-1:0] mem [2][DEPTH];
    logic [AW-1:0] wp  [2];
    logic [AW-1:0] rp  [2];
    logic [CW-1:0] cnt [2];
    logic          fill_full;
    logic          push;
    logic          pop;
    logic [DW-1:0] sel_flit;
    logic [DW-1:0] hop_flit;
    logic [RW-1:0] rr;

    function automatic logic [AW-1:0] inc_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign fill_vc   = vc_e'(~polarity);
    assign drain_vc  = vc_e'(polarity);
    assign fill_full = cnt[fill_vc] == CW'(DEPTH);
    assign so        = cnt[drain_vc] != '0;
    assign dout      = so ? mem[drain_vc][rp[drain_vc]] : '0;
    assign pop       = so && ro;
    assign push      = |fwd_en;
    assign vc_cnt    = {cnt[VC1], cnt[VC0]};

    // A full fill VC withholds advance, which zeroes the grant and freezes rr.
    rr_arbiter #(.N(NIN)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (fwd_v),
        .advance (!fill_full),
        .gnt     (fwd_en),
        .ptr     (rr)
    );

    // fwd_en is one-hot, so OR-ing the masked inputs selects the winner's flit.
    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < NIN; i++)
            sel_flit = sel_flit | (fwd_en[i] ? fwd_d[i*DW +: DW] : '0);
        hop_flit                   = sel_flit;
        hop_flit[HOP_MSB:HOP_LSB]  = sel_flit[HOP_MSB:HOP_LSB] >> 1;
    end

    // Push and pop always target different VCs, so their updates never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < 2; v++) begin
                wp[v]  <= '0;
                rp[v]  <= '0;
                cnt[v] <= '0;
                for (int e = 0; e < DEPTH; e++)
                    mem[v][e] <= '0;
            end
        end else begin
            if (push) begin
                mem[fill_vc][wp[fill_vc]] <= hop_flit;
                wp[fill_vc]               <= inc_ptr(wp[fill_vc]);
                cnt[fill_vc]              <= cnt[fill_vc] + CW'(1);
            end
            if (pop) begin
                rp[drain_vc]  <= inc_ptr(rp[drain_vc]);
                cnt[drain_vc] <= cnt[drain_vc] - CW'(1);
            end
        end
    end

    // The input sitting at rr, if valid and space exists, must always win.
    always_ff @(posedge clk) begin
        if (!reset && !fill_full && fwd_v[rr])
            assert (fwd_en[rr]);
    end
endmodule

// File: tb/tb_vc_output_port.sv
module tb_vc_output_port;
    localparam int DW = 64, NIN = 4, DEPTH = 2;

    logic              clk = 1'b0;
    logic              reset, polarity, ro, so;
    logic [NIN-1:0]    fwd_v, fwd_en;
    logic [NIN*DW-1:0] fwd_d;
    logic [DW-1:0]     dout;
    logic [3:0]        vc_cnt;

    int n_cmp = 0, n_err = 0;
    logic [63:0] q0[$], q1[$];
    int rr_m = 0;

    always #5 clk = ~clk;

    vc_output_port #(.DW(DW), .NIN(NIN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .polarity(polarity), .fwd_v(fwd_v), .fwd_d(fwd_d),
        .fwd_en(fwd_en), .so(so), .ro(ro), .dout(dout), .vc_cnt(vc_cnt)
    );

    function automatic logic [63:0] hop(input logic [63:0] f);
        logic [63:0] r;
        r = f;
        r[55:48] = f[55:48] / 8'd2;
        return r;
    endfunction

    function automatic int fill_size();
        return polarity ? q0.size() : q1.size();
    endfunction

    function automatic logic [3:0] exp_en();
        int idx;
        if (fill_size() >= DEPTH) return 4'b0;
        for (int k = 0; k < NIN; k++) begin
            idx = (rr_m + k) % NIN;
            if (((fwd_v >> idx) & 4'b1) != 4'b0) return 4'(1 << idx);
        end
        return 4'b0;
    endfunction

    function automatic logic exp_so();
        return polarity ? (q1.size() != 0) : (q0.size() != 0);
    endfunction

    function automatic logic [63:0] exp_do();
        if (polarity) return (q1.size() != 0) ? q1[0] : 64'd0;
        return (q0.size() != 0) ? q0[0] : 64'd0;
    endfunction

    function automatic logic [3:0] exp_cnt();
        return {2'(q1.size()), 2'(q0.size())};
    endfunction

    task automatic model_tick();
        logic [3:0]  en;
        logic [63:0] f;
        if (reset) begin
            q0.delete();
            q1.delete();
            rr_m = 0;
            return;
        end
        en = exp_en();
        if (ro && exp_so()) begin
            if (polarity) f = q1.pop_front();
            else          f = q0.pop_front();
        end
        for (int i = 0; i < NIN; i++) begin
            if (en == 4'(1 << i)) begin
                f = hop(fwd_d[i*DW +: DW]);
                if (polarity) q0.push_back(f);
                else          q1.push_back(f);
                rr_m = (i + 1) % NIN;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NIN * 2; i++) fwd_d[i*32 +: 32] = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        polarity = 1'($urandom);
        ro = 1'($urandom);
        fwd_v = 4'($urandom);
        rand_data();
        tick();
        tick();
        reset = 1'b0; fwd_v = '0; ro = 1'b0; polarity = 1'b0;
        @(negedge clk);
        n_cmp++; if (so !== 1'b0) begin n_err++; $display("FAIL reset_so: got %b want 0", so); end
        n_cmp++; if (dout !== 64'd0) begin n_err++; $display("FAIL reset_do: got %h want 0", dout); end
        n_cmp++; if (vc_cnt !== 4'd0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", vc_cnt); end
        n_cmp++; if (fwd_en !== 4'd0) begin n_err++; $display("FAIL reset_en: got %b want 0", fwd_en); end
        tick();
    endtask

    task automatic test_single_push();
        polarity = 1'b0; ro = 1'b0; fwd_v = 4'b0001;
        fwd_d = '0;
        fwd_d[63:0] = 64'h0A80_0000_0000_0001;
        @(negedge clk);
        n_cmp++; if (fwd_en !== 4'b0001) begin n_err++; $display("FAIL single_en: got %b want 0001", fwd_en); end
        tick();
        fwd_v = '0;
        @(negedge clk);
        n_cmp++; if (vc_cnt !== 4'b0100) begin n_err++; $display("FAIL single_cnt: got %b want 0100", vc_cnt); end
        polarity = 1'b1; ro = 1'b1;
        #1;
        n_cmp++; if (so !== 1'b1) begin n_err++; $display("FAIL single_so: got %b want 1", so); end
        n_cmp++; if (dout !== 64'h0A40_0000_0000_0001) begin n_err++; $display("FAIL single_do: got %h want 0a40000000000001", dout); end
        tick();
        @(negedge clk);
        n_cmp++; if (vc_cnt !== 4'b0000) begin n_err++; $display("FAIL single_drain: got %b want 0000", vc_cnt); end
        n_cmp++; if (so !== 1'b0) begin n_err++; $display("FAIL single_so_low: got %b want 0", so); end
    endtask

    task automatic test_round_robin();
        pulse_reset();
        fwd_v = 4'b1111; ro = 1'b1;
        for (int c = 0; c < 8; c++) begin
            polarity = 1'(c);
            rand_data();
            @(negedge clk);
            n_cmp++;
            if (fwd_en !== 4'(1 << (c % 4)) || fwd_en !== exp_en()) begin
                n_err++; $display("FAIL rr_seq[%0d]: got %b want %b", c, fwd_en, 4'(1 << (c % 4)));
            end
            tick();
        end
    endtask

    task automatic test_full();
        pulse_reset();
        polarity = 1'b0; ro = 1'b0; fwd_v = 4'b0011;
        rand_data();
        @(negedge clk);
        n_cmp++; if (fwd_en !== 4'b0001) begin n_err++; $display("FAIL full_g0: got %b want 0001", fwd_en); end
        tick();
        @(negedge clk);
        n_cmp++; if (fwd_en !== 4'b0010) begin n_err++; $display("FAIL full_g1: got %b want 0010", fwd_en); end
        tick();
        @(negedge clk);
        n_cmp++; if (fwd_en !== 4'b0000) begin n_err++; $display("FAIL full_block: got %b want 0000", fwd_en); end
        n_cmp++; if (vc_cnt !== 4'b1000) begin n_err++; $display("FAIL full_cnt: got %b want 1000", vc_cnt); end
        tick();
        fwd_v = 4'b1111;
        @(negedge clk);
        n_cmp++; if (fwd_en !== 4'b0000) begin n_err++; $display("FAIL full_block_all: got %b want 0000", fwd_en); end
        tick();
        polarity = 1'b1;
        @(negedge clk);
        n_cmp++; if (fwd_en !== 4'b0100) begin n_err++; $display("FAIL full_rr_held: got %b want 0100", fwd_en); end
        n_cmp++; if (so !== 1'b1 || dout !== exp_do()) begin n_err++; $display("FAIL full_head: got %b/%h want 1/%h", so, dout, exp_do()); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b;
        logic [63:0] want [4];
        logic        ro_seq [4];
        pulse_reset();
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        polarity = 1'b1; ro = 1'b0; fwd_v = 4'b0001;
        fwd_d[63:0] = a;
        tick();
        fwd_d[63:0] = b;
        tick();
        fwd_v = '0; polarity = 1'b0;
        @(negedge clk);
        n_cmp++; if (vc_cnt !== 4'b0010) begin n_err++; $display("FAIL bp_fill: got %b want 0010", vc_cnt); end
        want = '{hop(a), hop(a), hop(b), hop(b)};
        ro_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 4; c++) begin
            ro = ro_seq[c];
            #1;
            n_cmp++;
            if (so !== 1'b1 || dout !== want[c]) begin
                n_err++; $display("FAIL bp_step[%0d]: got %b/%h want 1/%h", c, so, dout, want[c]);
            end
            tick();
            @(negedge clk);
        end
        n_cmp++; if (so !== 1'b0 || dout !== 64'd0 || vc_cnt !== 4'd0) begin
            n_err++; $display("FAIL bp_empty: got %b/%h/%b want 0/0/0000", so, dout, vc_cnt);
        end
        ro = 1'b0;
    endtask

    task automatic test_mid_reset();
        pulse_reset();
        fwd_v = 4'b1111; ro = 1'b0; polarity = 1'b1;
        rand_data();
        tick();
        polarity = 1'b0;
        tick();
        fwd_v = '0;
        @(negedge clk);
        n_cmp++; if (vc_cnt !== 4'b0101) begin n_err++; $display("FAIL mid_fill: got %b want 0101", vc_cnt); end
        reset = 1'b1; ro = 1'b1;
        tick();
        reset = 1'b0; ro = 1'b0;
        @(negedge clk);
        n_cmp++; if (vc_cnt !== 4'd0 || so !== 1'b0 || dout !== 64'd0) begin
            n_err++; $display("FAIL mid_clear: got %b/%b/%h want 0000/0/0", vc_cnt, so, dout);
        end
        fwd_v = 4'b1111;
        #1;
        n_cmp++; if (fwd_en !== 4'b0001) begin n_err++; $display("FAIL mid_rr: got %b want 0001", fwd_en); end
        tick();
        fwd_v = '0;
    endtask

    task automatic test_random();
        pulse_reset();
        polarity = 1'b0;
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) polarity = ~polarity;
            fwd_v = 4'($urandom);
            ro = ($urandom_range(0, 2) != 0);
            rand_data();
            @(negedge clk);
            n_cmp++;
            if (fwd_en !== exp_en() || so !== exp_so() || dout !== exp_do() || vc_cnt !== exp_cnt()) begin
                n_err++;
                $display("FAIL rand[%0d]: got en=%b so=%b do=%h cnt=%b want en=%b so=%b do=%h cnt=%b",
                         c, fwd_en, so, dout, vc_cnt, exp_en(), exp_so(), exp_do(), exp_cnt());
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; polarity = 1'b0; ro = 1'b0; fwd_v = '0; fwd_d = '0;
        test_reset();
        test_single_push();
        test_round_robin();
        test_full();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
